mips_int_ctrl: RTL
==================

Name: mips_int_ctrl

Overview:
- Interrupt controller for the 5-stage MIPS core. It collects external interrupt lines, arbitrates among them, and chooses a precise point in the pipeline at which to take an interrupt.
- It sequences entry into the handler (flush, redirect, EPC capture) and the return on eret. Nesting is not supported: exactly one interrupt is serviced at a time.
- Sits beside the PC/hazard unit. Its flush and redirect outputs override normal PC selection.

Parameters:
- IRQ_NUM, 4, number of external interrupt lines; index 0 has the highest priority.
- HANDLER_ADDR, 32'h0000_0100, PC loaded on interrupt entry.
- SYNC_STAGES, 2, synchronizer flops per irq line (minimum 2).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- irq  in  IRQ_NUM  asynchronous interrupt lines from the board; rising-edge sensitive.
- int_en  in  1  global interrupt enable.
- int_mask  in  IRQ_NUM  per-line enable; 1 = enabled.
- commit_valid  in  1  instruction in MEM is valid and will commit this cycle.
- commit_pc  in  32  PC of the oldest uncommitted instruction (the one in EX).
- commit_ds  in  1  that instruction is in a branch delay slot.
- pipe_stall  in  1  the pipeline is frozen this cycle.
- eret_commit  in  1  an eret instruction commits this cycle.
- int_flush  out  1  one-cycle pulse; kills IF/ID/EX.
- pc_redirect  out  1  one-cycle pulse; PC <= redirect_pc.
- redirect_pc  out  32  HANDLER_ADDR on entry, epc on return.
- epc  out  32  saved return PC.
- cause  out  IRQ_NUM  one-hot line being serviced.
- in_handler  out  1  high from entry until the return redirect.
- pending  out  IRQ_NUM  latched, not-yet-serviced edges.

Behaviour:
- Reset (rst==0 at a posedge) clears all outputs, synchronizers, edge history and pending to 0, and puts the FSM in IDLE. Reset mid-handler drops the handler state with no redirect.
- Input path: irq passes through SYNC_STAGES flops. A rising edge (synchronized value 1, previous value 0) sets pending[i]. The edge is detected SYNC_STAGES+1 cycles after irq rises.
- Pending bits: pending[i] stays set until line i is taken. If the same line is set and cleared in one cycle, set wins. A line held high generates only one edge.
- Eligibility: eligible = pending & int_mask, gated by int_en. The winner is the lowest-index eligible bit.
- FSM states: IDLE, WAIT_SAFE, ENTER, HANDLER, RETURN.
- IDLE: if eligible is nonzero, go to WAIT_SAFE.
- WAIT_SAFE:
  - If eligible becomes 0 (masked or disabled), return to IDLE.
  - Else if commit_valid and !pipe_stall:
    - latch epc = commit_ds ? commit_pc-4 : commit_pc;
    - latch cause = winner one-hot;
    - clear that pending bit;
    - go to ENTER.
- ENTER: assert int_flush=1, pc_redirect=1, redirect_pc=HANDLER_ADDR for exactly one cycle. Set in_handler=1, then go to HANDLER. A pipe_stall during ENTER does not delay the pulse, because the flush overrides the stall.
- HANDLER: new edges keep latching into pending but are not taken. On eret_commit, go to RETURN. eret_commit in any other state is ignored.
- RETURN: assert pc_redirect=1, int_flush=1, redirect_pc=epc for one cycle. Clear in_handler and cause, then go to IDLE. A line still pending is re-evaluated from IDLE on the next cycle, so at least one handler instruction-free cycle separates services.
- Latency: from commit_valid in WAIT_SAFE, the redirect appears 1 cycle later. Minimum latency from irq rise to redirect is SYNC_STAGES+3 cycles.
- epc and cause hold their value until the next entry or reset. redirect_pc is 0 whenever pc_redirect is 0.
- Arithmetic: commit_pc-4 is modulo 2^32, so 0 wraps to 32'hFFFF_FFFC.

Decomposition:
- Shared package mips_int_pkg holds:
  - FSM state encoding (3-bit localparams);
  - the HANDLER_ADDR default;
  - the PC width constant (32).
- One natural sub-module, irq_sync_edge: synchronizer plus rising-edge detect, instantiated per line. Arbitration and the FSM stay in the top.

Test Plan:
- Basic entry and return: with IRQ_NUM=4, int_en=1, int_mask=4'hF, raise irq[2] and hold commit_valid=1, commit_pc=32'h40, commit_ds=0.
  - Expect int_flush and pc_redirect pulses with redirect_pc=32'h100, epc=32'h40, cause=4'b0100, at 5 cycles after the irq rise.
  - Then pulse eret_commit; the next cycle expects redirect_pc=32'h40 and in_handler falls.
- Delay slot: same as above but commit_pc=32'h88, commit_ds=1 -> epc=32'h84.
- Priority and queueing: raise irq[3] and irq[1] in the same cycle.
  - Expect cause=4'b0010 first, with pending=4'b1000 held.
  - After eret, the second entry has cause=4'b1000.
- No nesting: raise irq[0] while in_handler=1 -> pending[0]=1 and no int_flush until after RETURN, then entry with cause=4'b0001.
- Masking and safe point: pending[1] is set while int_mask[1]=0 -> no entry.
  - Unmask while pipe_stall=1 -> remains in WAIT_SAFE.
  - Release the stall -> entry on the first commit_valid.
- Reset mid-handler: drive rst=0 for 1 cycle in HANDLER -> in_handler=0, epc=0, pending=0, and no redirect follows.

Source files
------------

// File: rtl/mips_int_pkg.sv
// Shared constants for the MIPS interrupt controller: PC width, handler vector, FSM encoding.
package mips_int_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] HANDLER_ADDR_DEF = 32'h0000_0100;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SAFE = 3'd1;
    localparam logic [2:0] ST_ENTER     = 3'd2;
    localparam logic [2:0] ST_HANDLER   = 3'd3;
    localparam logic [2:0] ST_RETURN    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_SAFE = ST_WAIT_SAFE,
        S_ENTER     = ST_ENTER,
        S_HANDLER   = ST_HANDLER,
        S_RETURN    = ST_RETURN
    } int_state_e;

endpackage

// File: rtl/mips_int_ctrl_irq_sync_edge.sv
// One irq line: SYNC_STAGES-flop synchronizer then rising-edge detect.
// edge_o is a 1-cycle pulse SYNC_STAGES cycles after irq_i rises; no backpressure.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_int_ctrl.sv
// Interrupt controller: latches irq edges, picks lowest-index eligible line, enters the handler
// at a commit point (redirect 1 cycle after the safe commit) and returns on eret; no nesting.
module mips_int_ctrl
    import mips_int_pkg::*;
#(
    parameter int              IRQ_NUM      = 4,
    parameter logic [PC_W-1:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int              SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq,
    input  logic               int_en,
    input  logic [IRQ_NUM-1:0] int_mask,
    input  logic               commit_valid,
    input  logic [PC_W-1:0]    commit_pc,
    input  logic               commit_ds,
    input  logic               pipe_stall,
    input  logic               eret_commit,
    output logic               int_flush,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    epc,
    output logic [IRQ_NUM-1:0] cause,
    output logic               in_handler,
    output logic [IRQ_NUM-1:0] pending
);

    int_state_e         state_q, state_d;
    logic [IRQ_NUM-1:0] pending_q, pending_d;
    logic [IRQ_NUM-1:0] cause_q, cause_d;
    logic [PC_W-1:0]    epc_q, epc_d;
    logic               in_handler_q, in_handler_d;

    logic [IRQ_NUM-1:0] edge_vec;
    logic [IRQ_NUM-1:0] eligible;
    logic [IRQ_NUM-1:0] winner_oh;
    logic               take;
    logic               flush_c;
    logic               redirect_c;
    logic [PC_W-1:0]    redirect_pc_c;

    for (genvar g = 0; g < IRQ_NUM; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq_i (irq[g]),
            .edge_o(edge_vec[g])
        );
    end

    assign eligible = int_en ? (pending_q & int_mask) : '0;

    // Scan from the top down so the lowest index ends up as the winner.
    always_comb begin
        winner_oh = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_oh    = '0;
                winner_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        in_handler_d  = in_handler_q;
        take          = 1'b0;
        flush_c       = 1'b0;
        redirect_c    = 1'b0;
        redirect_pc_c = '0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) state_d = S_WAIT_SAFE;
            end
            S_WAIT_SAFE: begin
                if (eligible == '0) begin
                    state_d = S_IDLE;
                end else if (commit_valid && !pipe_stall) begin
                    epc_d   = commit_ds ? (commit_pc - 32'd4) : commit_pc;
                    cause_d = winner_oh;
                    take    = 1'b1;
                    state_d = S_ENTER;
                end
            end
            // Flush takes priority over pipe_stall, so the pulse is never held off.
            S_ENTER: begin
                flush_c       = 1'b1;
                redirect_c    = 1'b1;
                redirect_pc_c = HANDLER_ADDR;
                in_handler_d  = 1'b1;
                state_d       = S_HANDLER;
            end
            S_HANDLER: begin
                if (eret_commit) state_d = S_RETURN;
            end
            S_RETURN: begin
                flush_c       = 1'b1;
                redirect_c    = 1'b1;
                redirect_pc_c = epc_q;
                in_handler_d  = 1'b0;
                cause_d       = '0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new edge on the line being taken in the same cycle survives the clear.
    assign pending_d = (pending_q & ~(take ? winner_oh : '0)) | edge_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            cause_q      <= '0;
            epc_q        <= '0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            in_handler_q <= in_handler_d;
        end
    end

    assign int_flush   = flush_c;
    assign pc_redirect = redirect_c;
    assign redirect_pc = redirect_pc_c;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign in_handler  = in_handler_q;
    assign pending     = pending_q;

endmodule
